// File: rtl/ex_cplt_pipe_if.sv
// Issue, branch-resolution and completion signals of the execute completion pipe.
// The master drives issue/resolution and observes completion; the slave is the pipe.
interface ex_cplt_pipe_if #(
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5,
  parameter int FU_SEL_W  = 3
);
  logic                 iss_vld_i;
  logic [PRF_IDX_W-1:0] iss_dest_tag_i;
  logic [FU_SEL_W-1:0]  iss_fu_sel_i;
  logic [ROB_IDX_W-1:0] iss_rob_idx_i;
  logic [BR_MASK_W-1:0] iss_br_mask_i;
  logic                 rob_br_pred_correct_i;
  logic                 rob_br_recovery_i;
  logic [BR_MASK_W-1:0] rob_br_tag_fix_i;
  logic                 cplt_vld_o;
  logic [ROB_IDX_W-1:0] cplt_rob_idx_o;
  logic                 cdb_vld_o;
  logic [PRF_IDX_W-1:0] cdb_tag_o;
  logic                 busy_o;
  logic                 collision_err_o;

  modport master (
    output iss_vld_i, iss_dest_tag_i, iss_fu_sel_i, iss_rob_idx_i, iss_br_mask_i,
    output rob_br_pred_correct_i, rob_br_recovery_i, rob_br_tag_fix_i,
    input  cplt_vld_o, cplt_rob_idx_o, cdb_vld_o, cdb_tag_o, busy_o, collision_err_o
  );

  modport slave (
    input  iss_vld_i, iss_dest_tag_i, iss_fu_sel_i, iss_rob_idx_i, iss_br_mask_i,
    input  rob_br_pred_correct_i, rob_br_recovery_i, rob_br_tag_fix_i,
    output cplt_vld_o, cplt_rob_idx_o, cdb_vld_o, cdb_tag_o, busy_o, collision_err_o
  );
endinterface

// File: rtl/ex_cplt_pipe.sv
// Fixed-latency completion shift pipe: ops enter the slot matching their FU latency
// and shift toward slot 0, which drives ROB completion and the CDB broadcast.
module ex_cplt_pipe #(
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5,
  parameter int FU_SEL_W  = 3,
  parameter int LAT_ALU   = 1,
  parameter int LAT_BR    = 1,
  parameter int LAT_LD    = 2,
  parameter int LAT_ST    = 1,
  parameter int LAT_MULT  = 4,
  parameter int LAT_MAX   = 4,
  parameter int ZERO_TAG  = 0
) (
  input logic clk,
  input logic rst,
  ex_cplt_pipe_if.slave bus
);

  localparam logic [FU_SEL_W-1:0] FU_NONE = FU_SEL_W'(0);
  localparam logic [FU_SEL_W-1:0] FU_ALU  = FU_SEL_W'(1);
  localparam logic [FU_SEL_W-1:0] FU_UBR  = FU_SEL_W'(2);
  localparam logic [FU_SEL_W-1:0] FU_CBR  = FU_SEL_W'(3);
  localparam logic [FU_SEL_W-1:0] FU_LD   = FU_SEL_W'(4);
  localparam logic [FU_SEL_W-1:0] FU_ST   = FU_SEL_W'(5);
  localparam logic [FU_SEL_W-1:0] FU_MUL  = FU_SEL_W'(6);

  typedef struct packed {
    logic                 vld;
    logic [PRF_IDX_W-1:0] dest_tag;
    logic [FU_SEL_W-1:0]  fu_sel;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [BR_MASK_W-1:0] br_mask;
  } slot_t;

  slot_t                r_slot [LAT_MAX];
  slot_t                w_next [LAT_MAX];
  logic                 r_collision;
  slot_t                w_in;
  int                   w_ins_lat;
  logic                 w_recov;
  logic                 w_clear;
  logic [BR_MASK_W-1:0] w_fix;
  logic [LAT_MAX-1:0]   w_hit;
  logic [LAT_MAX-1:0]   w_shift_vld;
  logic [LAT_MAX-1:0]   w_vld_vec;
  logic                 w_collide;
  logic                 w_s0_kill;
  logic                 w_cplt_vld;
  logic                 w_cdb_vld;

  // Recovery wins over a simultaneous correct-prediction for the same tag.
  assign w_recov = bus.rob_br_recovery_i;
  assign w_clear = bus.rob_br_pred_correct_i && !bus.rob_br_recovery_i;
  assign w_fix   = bus.rob_br_tag_fix_i;

  always_comb begin
    w_ins_lat = 0;
    case (bus.iss_fu_sel_i)
      FU_NONE:        w_ins_lat = 0;
      FU_ALU:         w_ins_lat = LAT_ALU;
      FU_UBR, FU_CBR: w_ins_lat = LAT_BR;
      FU_LD:          w_ins_lat = LAT_LD;
      FU_ST:          w_ins_lat = LAT_ST;
      FU_MUL:         w_ins_lat = LAT_MULT;
      default:        w_ins_lat = LAT_MAX;
    endcase
  end

  always_comb begin
    w_in          = '0;
    w_in.vld      = bus.iss_vld_i && (bus.iss_fu_sel_i != FU_NONE) &&
                    !(w_recov && (|(bus.iss_br_mask_i & w_fix)));
    w_in.dest_tag = bus.iss_dest_tag_i;
    w_in.fu_sel   = bus.iss_fu_sel_i;
    w_in.rob_idx  = bus.iss_rob_idx_i;
    w_in.br_mask  = w_clear ? (bus.iss_br_mask_i & ~w_fix) : bus.iss_br_mask_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LAT_MAX; gi++) begin : g_slot
      slot_t w_src;
      slot_t w_sh;

      if (gi < LAT_MAX - 1) begin : g_mid
        assign w_src = r_slot[gi+1];
      end else begin : g_top
        assign w_src = '0;
      end

      // Squash/clear is applied before the collision test so a squashed op never collides.
      always_comb begin
        w_sh = w_src;
        if (w_recov && (|(w_src.br_mask & w_fix)))
          w_sh.vld = 1'b0;
        if (w_clear)
          w_sh.br_mask = w_src.br_mask & ~w_fix;
      end

      assign w_shift_vld[gi] = w_sh.vld;
      assign w_hit[gi]       = w_in.vld && (w_ins_lat == gi + 1);
      assign w_next[gi]      = (w_hit[gi] && !w_sh.vld) ? w_in : w_sh;
      assign w_vld_vec[gi]   = r_slot[gi].vld;
    end
  endgenerate

  assign w_collide = |(w_hit & w_shift_vld);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT_MAX; k++)
        r_slot[k] <= '0;
      r_collision <= 1'b0;
    end else begin
      for (int k = 0; k < LAT_MAX; k++)
        r_slot[k] <= w_next[k];
      r_collision <= w_collide;
    end
  end

  // A completing op hit by this cycle's recovery must not reach the ROB or CDB.
  assign w_s0_kill  = w_recov && (|(r_slot[0].br_mask & w_fix));
  assign w_cplt_vld = r_slot[0].vld && !w_s0_kill;
  assign w_cdb_vld  = w_cplt_vld && (r_slot[0].fu_sel != FU_ST) &&
                      (r_slot[0].fu_sel != FU_CBR) &&
                      (r_slot[0].dest_tag != PRF_IDX_W'(ZERO_TAG));

  assign bus.cplt_vld_o      = w_cplt_vld;
  assign bus.cplt_rob_idx_o  = r_slot[0].rob_idx;
  assign bus.cdb_vld_o       = w_cdb_vld;
  assign bus.cdb_tag_o       = w_cdb_vld ? r_slot[0].dest_tag : '0;
  assign bus.busy_o          = |w_vld_vec;
  assign bus.collision_err_o = r_collision;

endmodule

// File: tb/tb_ex_cplt_pipe.sv
// Randomized bench for ex_cplt_pipe against a schedule-based model: each in-flight op
// carries the absolute cycle it is due to complete.
module tb_ex_cplt_pipe;
  localparam int PRF_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
  localparam int BR_MASK_W = 5;
  localparam int FU_SEL_W  = 3;
  localparam int LAT_ALU   = 1;
  localparam int LAT_BR    = 1;
  localparam int LAT_LD    = 2;
  localparam int LAT_ST    = 1;
  localparam int LAT_MULT  = 4;
  localparam int LAT_MAX   = 4;
  localparam int ZERO_TAG  = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_cplt_pipe_if #(.PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W),
                    .BR_MASK_W(BR_MASK_W), .FU_SEL_W(FU_SEL_W)) bus ();

  ex_cplt_pipe #(
    .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W), .FU_SEL_W(FU_SEL_W),
    .LAT_ALU(LAT_ALU), .LAT_BR(LAT_BR), .LAT_LD(LAT_LD), .LAT_ST(LAT_ST),
    .LAT_MULT(LAT_MULT), .LAT_MAX(LAT_MAX), .ZERO_TAG(ZERO_TAG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int tag;
    int fu;
    int rob;
    int mask;
    int due;
  } op_t;

  op_t q[$];
  int  cyc;
  bit  m_col;
  int  n_vec;
  int  n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int fu);
    case (fu)
      1:       return LAT_ALU;
      2, 3:    return LAT_BR;
      4:       return LAT_LD;
      5:       return LAT_ST;
      6:       return LAT_MULT;
      7:       return LAT_MAX;
      default: return 0;
    endcase
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model at the edge.
  task automatic step(input bit v, input int tag, input int fu, input int rob, input int mask,
                      input bit pc, input bit rec, input int fix, input bit r);
    bit  has;
    bit  busy;
    bit  e_cplt;
    bit  e_cdb;
    bit  clash;
    int  d;
    int  m;
    op_t c;
    bus.iss_vld_i             = v;
    bus.iss_dest_tag_i        = PRF_IDX_W'(tag);
    bus.iss_fu_sel_i          = FU_SEL_W'(fu);
    bus.iss_rob_idx_i         = ROB_IDX_W'(rob);
    bus.iss_br_mask_i         = BR_MASK_W'(mask);
    bus.rob_br_pred_correct_i = pc;
    bus.rob_br_recovery_i     = rec;
    bus.rob_br_tag_fix_i      = BR_MASK_W'(fix);
    rst                       = r;
    #1;
    has  = 1'b0;
    busy = (q.size() != 0);
    c    = '{0, 0, 0, 0, 0};
    foreach (q[i]) if (q[i].due == cyc) begin has = 1'b1; c = q[i]; end
    e_cplt = has && !(rec && ((c.mask & fix) != 0));
    e_cdb  = e_cplt && (c.fu != 5) && (c.fu != 3) && (c.tag != ZERO_TAG);
    chk("cplt_vld", 32'(bus.cplt_vld_o), 32'(e_cplt));
    if (e_cplt) chk("cplt_rob", 32'(bus.cplt_rob_idx_o), 32'(c.rob));
    chk("cdb_vld", 32'(bus.cdb_vld_o), 32'(e_cdb));
    chk("cdb_tag", 32'(bus.cdb_tag_o), e_cdb ? 32'(c.tag) : 32'd0);
    chk("busy", 32'(bus.busy_o), 32'(busy));
    chk("collision", 32'(bus.collision_err_o), 32'(m_col));
    $display("cyc %0d iss=%0d fu=%0d tag=%0d rob=%0d mask=%0d pc=%0d rec=%0d fix=%0d rst=%0d | cplt=%0d rob=%0d cdb=%0d tag=%0d busy=%0d col=%0d",
             cyc, v, fu, tag, rob, mask, pc, rec, fix, r, bus.cplt_vld_o, bus.cplt_rob_idx_o,
             bus.cdb_vld_o, bus.cdb_tag_o, bus.busy_o, bus.collision_err_o);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_col = 1'b0;
    end else begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].due <= cyc || (rec && ((q[i].mask & fix) != 0))) q.delete(i);
      if (pc && !rec) foreach (q[i]) q[i].mask = q[i].mask & ~fix;
      m_col = 1'b0;
      if (v && lat_of(fu) != 0 && !(rec && ((mask & fix) != 0))) begin
        d     = cyc + lat_of(fu);
        clash = 1'b0;
        foreach (q[i]) if (q[i].due == d) clash = 1'b1;
        m = (pc && !rec) ? (mask & ~fix) : mask;
        if (clash) m_col = 1'b1;
        else q.push_back('{tag, fu, rob, m, d});
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input int tag, input int fu, input int rob, input int mask);
    step(1, tag, fu, rob, mask, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    m_col = 1'b0;
    rst   = 1'b1;
    bus.iss_vld_i = 1'b0;
    bus.iss_dest_tag_i = '0;
    bus.iss_fu_sel_i = '0;
    bus.iss_rob_idx_i = '0;
    bus.iss_br_mask_i = '0;
    bus.rob_br_pred_correct_i = 1'b0;
    bus.rob_br_recovery_i = 1'b0;
    bus.rob_br_tag_fix_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rob", 32'(bus.cplt_rob_idx_o), 32'd0);
    idle(1);

    // single ALU op
    issue(12, 1, 3, 0);
    chk("alu_cdb_tag", 32'(bus.cdb_tag_o), 32'd12);
    chk("alu_rob", 32'(bus.cplt_rob_idx_o), 32'd3);
    idle(2);

    // MULT then ALU landing in the same slot
    issue(20, 6, 1, 0);
    idle(2);
    issue(21, 1, 2, 0);
    chk("col_tag", 32'(bus.cdb_tag_o), 32'd20);
    chk("col_err", 32'(bus.collision_err_o), 32'd1);
    idle(3);

    // LOAD squashed by recovery
    issue(9, 4, 4, 5'b00010);
    step(0, 0, 0, 0, 0, 0, 1, 5'b00010, 0);
    chk("squash_busy", 32'(bus.busy_o), 32'd0);
    idle(3);

    // MULT resolved correct, later recovery on same tag leaves it alone
    issue(5, 6, 6, 5'b00100);
    step(0, 0, 0, 0, 0, 1, 0, 5'b00100, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'b00100, 0);
    idle(1);
    chk("pc_cplt", 32'(bus.cplt_vld_o), 32'd1);
    chk("pc_tag", 32'(bus.cdb_tag_o), 32'd5);
    idle(2);

    // STORE and zero-tag ALU: complete without CDB
    issue(33, 5, 7, 0);
    chk("st_cplt", 32'(bus.cplt_vld_o), 32'd1);
    chk("st_rob", 32'(bus.cplt_rob_idx_o), 32'd7);
    chk("st_cdb", 32'(bus.cdb_vld_o), 32'd0);
    issue(ZERO_TAG, 1, 8, 0);
    chk("zt_cdb", 32'(bus.cdb_vld_o), 32'd0);
    idle(2);

    // back-to-back ALUs, then three MULTs killed by reset
    issue(40, 1, 10, 0);
    issue(41, 1, 11, 0);
    issue(42, 1, 12, 0);
    idle(1);
    issue(50, 6, 13, 0);
    issue(51, 6, 14, 0);
    issue(52, 6, 15, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_cplt", 32'(bus.cplt_vld_o), 32'd0);
    chk("rst_rob2", 32'(bus.cplt_rob_idx_o), 32'd0);
    idle(5);

    for (int n = 0; n < 600; n++) begin
      bit rv;
      bit rpc;
      bit rrec;
      bit rr;
      rv   = ($urandom_range(0, 9) < 6);
      rpc  = ($urandom_range(0, 9) == 0);
      rrec = ($urandom_range(0, 11) == 0);
      rr   = ($urandom_range(0, 99) == 0);
      step(rv, $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 31),
           $urandom_range(0, 31) & $urandom_range(0, 31), rpc, rrec,
           1 << $urandom_range(0, 4), rr);
    end
    idle(LAT_MAX + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ex_cplt_pipe.md
EX_CPLT_PIPE -- requirements
Module: ex_cplt_pipe

Interface
REQ-001 Parameter PRF_IDX_W, default 6, physical register tag width.
REQ-002 Parameter ROB_IDX_W, default 5, ROB index width.
REQ-003 Parameter BR_MASK_W, default 5, branch mask width.
REQ-004 Parameter FU_SEL_W, default 3, FU select width.
REQ-005 Parameters LAT_ALU=1, LAT_BR=1, LAT_LD=2, LAT_ST=1, LAT_MULT=4, LAT_MAX=4 (cycles); each LAT_* SHALL be in 1..LAT_MAX.
REQ-006 Parameter ZERO_TAG, default 0, tag that never broadcasts on the CDB.
REQ-007 FU_SEL encoding SHALL be NONE=0, ALU=1, UNCOND_BRANCH=2, COND_BRANCH=3, LOAD=4, STORE=5, MULT=6; code 7 SHALL use LAT_MAX.
REQ-008 clk  in  1  clock; all state on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 iss_vld_i  in  1  issued op valid, from the RS issue register.
REQ-011 iss_dest_tag_i  in  PRF_IDX_W  destination tag.
REQ-012 iss_fu_sel_i  in  FU_SEL_W  FU select.
REQ-013 iss_rob_idx_i  in  ROB_IDX_W  ROB entry.
REQ-014 iss_br_mask_i  in  BR_MASK_W  branch dependence mask.
REQ-015 rob_br_pred_correct_i  in  1  branch resolved correct.
REQ-016 rob_br_recovery_i  in  1  branch mispredict recovery.
REQ-017 rob_br_tag_fix_i  in  BR_MASK_W  one-hot resolved branch tag.
REQ-018 cplt_vld_o  out  1  op completes this cycle (to ROB).
REQ-019 cplt_rob_idx_o  out  ROB_IDX_W  completing ROB entry.
REQ-020 cdb_vld_o  out  1  CDB broadcast valid.
REQ-021 cdb_tag_o  out  PRF_IDX_W  CDB broadcast tag.
REQ-022 busy_o  out  1  any op in flight.
REQ-023 collision_err_o  out  1  one-cycle pulse, slot conflict detected.

Function
REQ-024 Block SHALL hold LAT_MAX slots S[0..LAT_MAX-1], each {vld, dest_tag, fu_sel, rob_idx, br_mask}; S[0] is the completion register.
REQ-025 Each edge, S[k] <= S[k+1] for k < LAT_MAX-1; S[LAT_MAX-1] loads invalid unless written by insertion.
REQ-026 An op with iss_vld_i=1 at edge T SHALL be written into S[lat-1], lat from fu_sel; it appears on outputs exactly lat cycles after edge T (first visible cycle after edge T+lat-1).
REQ-027 fu_sel=NONE with iss_vld_i=1 SHALL be ignored (no insertion, no error).
REQ-028 If the shifted-in content of S[lat-1] is valid at insertion, the resident op SHALL be kept, the incoming op dropped, collision_err_o=1 for the following cycle.
REQ-029 cplt_vld_o = S[0].vld and not squashed (REQ-032); cplt_rob_idx_o = S[0].rob_idx.
REQ-030 cdb_vld_o = cplt_vld_o and fu_sel not in {STORE, COND_BRANCH} and dest_tag != ZERO_TAG; cdb_tag_o = S[0].dest_tag, 0 when cdb_vld_o=0.
REQ-031 busy_o = OR of all slot vld bits.
REQ-032 Squash: when rob_br_recovery_i=1, any slot or incoming op with (br_mask & rob_br_tag_fix_i) != 0 SHALL be invalidated at the edge; S[0] so marked SHALL also be gated off cplt_vld_o/cdb_vld_o combinationally in that cycle.
REQ-033 Ops with no matching mask bit during recovery SHALL shift and insert normally.
REQ-034 When rob_br_pred_correct_i=1, the rob_br_tag_fix_i bit SHALL be cleared in every slot mask and in the incoming op mask before storage.
REQ-035 pred_correct and recovery asserted together SHALL be treated as recovery only.
REQ-036 Squashed ops SHALL never cause collision_err_o.
REQ-037 Back-to-back issue of equal-latency ops SHALL complete on consecutive cycles with no bubble.

Reset
REQ-038 On rst, all slot vld bits SHALL clear; cplt_vld_o=0, cdb_vld_o=0, cdb_tag_o=0, cplt_rob_idx_o=0, busy_o=0, collision_err_o=0 the following cycle.
REQ-039 rst mid-operation SHALL discard all in-flight ops with no completion issued; rst has priority over insertion and recovery.

Verification
REQ-040 ALU op tag=12 rob=3 issued at edge T -> cplt_vld_o=1, cdb_tag_o=12, cplt_rob_idx_o=3 for one cycle after edge T; busy_o then 0.
REQ-041 MULT tag=20 at T, ALU tag=21 at T+3 -> tag 20 after T+3, tag 21 after T+3 on next cycle? No: MULT completes after edge T+3, ALU after edge T+3 -> collision_err_o=1, only tag 20 completes.
REQ-042 LOAD tag=9 mask=00010 at T, recovery fix=00010 at T+1 -> no cplt_vld_o, busy_o=0 after T+1.
REQ-043 MULT mask=00100 at T, pred_correct fix=00100 at T+1, recovery fix=00100 at T+2 -> MULT completes after T+3.
REQ-044 STORE rob=7 -> cplt_vld_o=1, cplt_rob_idx_o=7, cdb_vld_o=0; ALU dest=ZERO_TAG -> cdb_vld_o=0.
REQ-045 Three MULTs in flight, rst asserted one cycle -> no completions, all outputs 0, busy_o=0.
